// File: rtl/ebr_wr_pkg.sv
// Shared constants and types for the EBR sub-word write coalescer.
// Lane modes are interleaved: in mode m a word is split into 2^m lanes, bit b belongs to lane b mod 2^m.
package ebr_wr_pkg;

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_X2   = 2'd1;
    localparam logic [1:0] MODE_X4   = 2'd2;
    localparam logic [1:0] MODE_X8   = 2'd3;

    localparam int MAX_LANES     = 8;
    localparam int WORD_W_NARROW = 16;
    localparam int WORD_W_WIDE   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } state_e;

    // Low bits of the lane field that are significant in a given mode.
    function automatic logic [2:0] lane_mask(input logic [1:0] mode);
        case (mode)
            MODE_FULL: return 3'b000;
            MODE_X2:   return 3'b001;
            MODE_X4:   return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ebr_lane_scatter.sv
// Spreads a narrow write onto its interleaved lane of a RAM word.
// Produces the per-bit write enable and the data placed at word bit j*R+lane.
module ebr_lane_scatter
    import ebr_wr_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [1:0]        mode,
    input  logic [2:0]        lane,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] enable,
    output logic [WORD_W-1:0] sdata
);

    if (WORD_W != WORD_W_NARROW && WORD_W != WORD_W_WIDE) begin : g_illegal_word_w
        $error("ebr_lane_scatter: WORD_W must be 16 or 32");
    end

    logic [2:0] lm;
    logic [2:0] sel;

    assign lm  = lane_mask(mode);
    assign sel = lane & lm;

    for (genvar b = 0; b < WORD_W; b++) begin : g_bit
        localparam logic [2:0] BIT_LANE = 3'(b % MAX_LANES);
        logic narrow_bit;

        // Word bit b takes narrow bit b/R; indices are constant per mode.
        always_comb begin
            case (mode)
                MODE_FULL: narrow_bit = data[b];
                MODE_X2:   narrow_bit = data[b/2];
                MODE_X4:   narrow_bit = data[b/4];
                default:   narrow_bit = data[b/8];
            endcase
        end

        assign enable[b] = ((BIT_LANE & lm) == sel);
        assign sdata[b]  = enable[b] & narrow_bit;
    end

endmodule

// File: rtl/ebr_wr_coalescer.sv
// Merges sub-word lane writes into one masked RAM word write.
// A partial word is issued when complete, on flush, on timeout, or when a request targets another word.
module ebr_wr_coalescer
    import ebr_wr_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [ADDR_W+2:0]   in_addr,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                flush,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WORD_W-1:0]   wr_data,
    output logic [WORD_W-1:0]   wr_mask
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [WORD_W-1:0]   en;
    logic [WORD_W-1:0]   sdata;
    logic [WORD_W-1:0]   merged_mask;
    logic [ADDR_W-1:0]   in_word;
    logic                addr_miss;
    logic                accept;
    logic                timeout_hit;

    ebr_lane_scatter #(.WORD_W(WORD_W)) u_scatter (
        .mode   (in_mode),
        .lane   (in_addr[2:0]),
        .data   (in_data),
        .enable (en),
        .sdata  (sdata)
    );

    assign in_word     = in_addr[ADDR_W+2:3];
    assign addr_miss   = (state_q == ST_ACC) && (in_word != addr_q);
    assign in_ready    = (state_q != ST_OUT) && !addr_miss;
    assign accept      = in_valid && in_ready;
    assign merged_mask = mask_q & ~en;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign wr_valid = (state_q == ST_OUT);
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign wr_mask  = mask_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = in_word;
                    data_d  = sdata;
                    mask_d  = ~en;
                    cnt_d   = '0;
                    state_d = (&en) ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                // An accepted merge outranks flush; the merged word is what gets issued.
                if (accept) begin
                    data_d  = (data_q & ~en) | (sdata & en);
                    mask_d  = merged_mask;
                    cnt_d   = '0;
                    if (merged_mask == '0 || flush) state_d = ST_OUT;
                end else if (flush || timeout_hit || (in_valid && addr_miss)) begin
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (wr_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '1;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
